// File: rtl/ddr_burst_ctrl_if.sv
// User-side and DDR2 local-side bundles for ddr_burst_ctrl; the controller uses usr.slave and lcl.master.
interface ddr_burst_ctrl_user_if #(
  parameter int ADDR_BITS     = 24,
  parameter int LEN_BITS      = 10,
  parameter int MEM_DATA_BITS = 32
);
  logic                     rd_burst_req;
  logic                     wr_burst_req;
  logic [LEN_BITS-1:0]      rd_burst_len;
  logic [LEN_BITS-1:0]      wr_burst_len;
  logic [ADDR_BITS-1:0]     rd_burst_addr;
  logic [ADDR_BITS-1:0]     wr_burst_addr;
  logic [MEM_DATA_BITS-1:0] wr_burst_data;
  logic                     wr_burst_data_req;
  logic [MEM_DATA_BITS-1:0] rd_burst_data;
  logic                     rd_burst_data_valid;
  logic                     rd_burst_finish;
  logic                     wr_burst_finish;
  logic                     burst_finish;

  modport master (
    output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
           rd_burst_addr, wr_burst_addr, wr_burst_data,
    input  wr_burst_data_req, rd_burst_data, rd_burst_data_valid,
           rd_burst_finish, wr_burst_finish, burst_finish
  );
  modport slave (
    input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
           rd_burst_addr, wr_burst_addr, wr_burst_data,
    output wr_burst_data_req, rd_burst_data, rd_burst_data_valid,
           rd_burst_finish, wr_burst_finish, burst_finish
  );
endinterface

interface ddr_burst_ctrl_local_if #(
  parameter int MEM_DATA_BITS   = 32,
  parameter int ADDR_BITS       = 24,
  parameter int LOCAL_SIZE_BITS = 3
);
  logic                       local_init_done;
  logic                       local_ready;
  logic                       local_burstbegin;
  logic                       local_read_req;
  logic                       local_write_req;
  logic [ADDR_BITS-1:0]       local_address;
  logic [LOCAL_SIZE_BITS-1:0] local_size;
  logic [MEM_DATA_BITS/8-1:0] local_be;
  logic [MEM_DATA_BITS-1:0]   local_wdata;
  logic                       local_rdata_valid;
  logic [MEM_DATA_BITS-1:0]   local_rdata;

  modport master (
    input  local_init_done, local_ready, local_rdata_valid, local_rdata,
    output local_burstbegin, local_read_req, local_write_req, local_address,
           local_size, local_be, local_wdata
  );
  modport slave (
    output local_init_done, local_ready, local_rdata_valid, local_rdata,
    input  local_burstbegin, local_read_req, local_write_req, local_address,
           local_size, local_be, local_wdata
  );
endinterface

// File: rtl/ddr_burst_ctrl.sv
// Splits user read/write bursts into <=MAX_BURST local sub-bursts; first write beat 1 cycle after grant,
// local_ready stalls commands/beats in place, finish pulses one cycle after the DONE state.
module ddr_burst_ctrl #(
  parameter int MEM_DATA_BITS   = 32,
  parameter int ADDR_BITS       = 24,
  parameter int LOCAL_SIZE_BITS = 3,
  parameter int MAX_BURST       = 4,
  parameter int LEN_BITS        = 10
) (
  input logic                    mem_clk,
  input logic                    rst_n,
  ddr_burst_ctrl_user_if.slave   usr,
  ddr_burst_ctrl_local_if.master lcl
);

  localparam logic [LEN_BITS-1:0]        LP_MAX_LEN = LEN_BITS'(MAX_BURST);
  localparam logic [LOCAL_SIZE_BITS-1:0] LP_MAX_SZ  = LOCAL_SIZE_BITS'(MAX_BURST);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_CMD, S_RD_DATA, S_DONE} state_t;

  state_t                     r_state;
  logic                       r_prio_wr;
  logic                       r_is_rd;
  logic [LEN_BITS-1:0]        r_len;
  logic [LEN_BITS-1:0]        r_remain;
  logic [LEN_BITS-1:0]        r_rd_cnt;
  logic [LOCAL_SIZE_BITS-1:0] r_sub_left;
  logic                       r_write_req;
  logic                       r_read_req;
  logic                       r_burstbegin;
  logic [ADDR_BITS-1:0]       r_address;
  logic [LOCAL_SIZE_BITS-1:0] r_size;
  logic                       r_rd_fin;
  logic                       r_wr_fin;

  function automatic logic [LOCAL_SIZE_BITS-1:0] f_min(input logic [LEN_BITS-1:0] n);
    if (n >= LP_MAX_LEN) f_min = LP_MAX_SZ;
    else                 f_min = n[LOCAL_SIZE_BITS-1:0];
  endfunction

  logic                       w_wr_acc;
  logic                       w_rd_acc;
  logic                       w_rd_beat;
  logic                       w_gnt_wr;
  logic                       w_gnt_rd;
  logic [LEN_BITS-1:0]        w_g_len;
  logic [ADDR_BITS-1:0]       w_g_addr;
  logic [LEN_BITS-1:0]        w_rem_dec;
  logic [LEN_BITS-1:0]        w_rem_after;
  logic [LEN_BITS-1:0]        w_cnt_inc;
  logic [ADDR_BITS-1:0]       w_next_addr;

  assign w_wr_acc    = r_write_req & lcl.local_ready;
  assign w_rd_acc    = r_read_req & lcl.local_ready;
  assign w_rd_beat   = lcl.local_rdata_valid & ((r_state == S_RD_CMD) | (r_state == S_RD_DATA));
  // Alternate on contention: r_prio_wr names the side that wins the next tie.
  assign w_gnt_wr    = lcl.local_init_done & usr.wr_burst_req & (~usr.rd_burst_req | r_prio_wr);
  assign w_gnt_rd    = lcl.local_init_done & usr.rd_burst_req & (~usr.wr_burst_req | ~r_prio_wr);
  assign w_g_len     = w_gnt_rd ? usr.rd_burst_len : usr.wr_burst_len;
  assign w_g_addr    = w_gnt_rd ? usr.rd_burst_addr : usr.wr_burst_addr;
  assign w_rem_dec   = r_remain - LEN_BITS'(1);
  assign w_rem_after = r_remain - LEN_BITS'(r_size);
  assign w_cnt_inc   = r_rd_cnt + LEN_BITS'(1);
  assign w_next_addr = r_address + ADDR_BITS'(r_size);

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_prio_wr    <= 1'b1;
      r_is_rd      <= 1'b0;
      r_len        <= '0;
      r_remain     <= '0;
      r_rd_cnt     <= '0;
      r_sub_left   <= '0;
      r_write_req  <= 1'b0;
      r_read_req   <= 1'b0;
      r_burstbegin <= 1'b0;
      r_address    <= '0;
      r_size       <= '0;
      r_rd_fin     <= 1'b0;
      r_wr_fin     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rd_fin <= 1'b0;
          r_wr_fin <= 1'b0;
          if (w_gnt_wr || w_gnt_rd) begin
            r_prio_wr  <= w_gnt_rd;
            r_is_rd    <= w_gnt_rd;
            r_len      <= w_g_len;
            r_remain   <= w_g_len;
            r_rd_cnt   <= '0;
            r_address  <= w_g_addr;
            r_size     <= f_min(w_g_len);
            r_sub_left <= f_min(w_g_len);
            if (w_g_len == '0) begin
              r_state <= S_DONE;
            end else if (w_gnt_rd) begin
              r_state      <= S_RD_CMD;
              r_read_req   <= 1'b1;
              r_burstbegin <= 1'b1;
            end else begin
              r_state      <= S_WR;
              r_write_req  <= 1'b1;
              r_burstbegin <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (w_wr_acc) begin
            r_remain     <= w_rem_dec;
            r_burstbegin <= 1'b0;
            if (r_remain == LEN_BITS'(1)) begin
              r_write_req <= 1'b0;
              r_state     <= S_DONE;
            end else if (r_sub_left == LOCAL_SIZE_BITS'(1)) begin
              r_address    <= w_next_addr;
              r_size       <= f_min(w_rem_dec);
              r_sub_left   <= f_min(w_rem_dec);
              r_burstbegin <= 1'b1;
            end else begin
              r_sub_left <= r_sub_left - LOCAL_SIZE_BITS'(1);
            end
          end
        end
        S_RD_CMD, S_RD_DATA: begin
          if (w_rd_acc) begin
            r_remain <= w_rem_after;
            if (w_rem_after == '0) begin
              r_read_req   <= 1'b0;
              r_burstbegin <= 1'b0;
              r_state      <= S_RD_DATA;
            end else begin
              r_address <= w_next_addr;
              r_size    <= f_min(w_rem_after);
            end
          end
          // Returns are counted while commands are still going out.
          if (w_rd_beat) begin
            r_rd_cnt <= w_cnt_inc;
            if (w_cnt_inc == r_len) begin
              r_read_req   <= 1'b0;
              r_burstbegin <= 1'b0;
              r_state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_rd_fin <= r_is_rd;
          r_wr_fin <= ~r_is_rd;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign usr.wr_burst_data_req   = w_wr_acc;
  assign usr.rd_burst_data       = lcl.local_rdata;
  assign usr.rd_burst_data_valid = w_rd_beat;
  assign usr.rd_burst_finish     = r_rd_fin;
  assign usr.wr_burst_finish     = r_wr_fin;
  assign usr.burst_finish        = r_rd_fin | r_wr_fin;

  assign lcl.local_burstbegin = r_burstbegin;
  assign lcl.local_read_req   = r_read_req;
  assign lcl.local_write_req  = r_write_req;
  assign lcl.local_address    = r_address;
  assign lcl.local_size       = r_size;
  assign lcl.local_be         = '1;
  assign lcl.local_wdata      = usr.wr_burst_data;

endmodule

// File: tb/tb_ddr_burst_ctrl.sv
// Scoreboard bench for ddr_burst_ctrl: stimulus queues expected commands/data/finishes, a negedge monitor pops them.
module tb_ddr_burst_ctrl;

  logic mem_clk;
  logic rst_n;

  ddr_burst_ctrl_user_if  #(.ADDR_BITS(24), .LEN_BITS(10), .MEM_DATA_BITS(32)) u_if ();
  ddr_burst_ctrl_local_if #(.MEM_DATA_BITS(32), .ADDR_BITS(24), .LOCAL_SIZE_BITS(3)) l_if ();

  ddr_burst_ctrl #(
    .MEM_DATA_BITS(32), .ADDR_BITS(24), .LOCAL_SIZE_BITS(3), .MAX_BURST(4), .LEN_BITS(10)
  ) dut (
    .mem_clk (mem_clk),
    .rst_n   (rst_n),
    .usr     (u_if),
    .lcl     (l_if)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] cmd_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] rd_q[$];
  logic [1:0]  fin_q[$];
  logic [23:0] pend_q[$];

  int exp_wseq = 0;
  int wr_idx = 0;
  int overlap = 0;
  int bad_init = 0;
  int stray_req = 0;
  int stray_done = 0;
  bit stray_now = 1'b0;
  bit abort_mode = 1'b0;
  bit bb_wait = 1'b0;
  bit tgl = 1'b0;
  bit ready_lvl = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] cmd(input logic rd, input logic [23:0] a, input logic [2:0] s);
    cmd = {3'b000, rd, a, 1'b0, s};
  endfunction

  task automatic push_wdata(input int n);
    for (int i = 0; i < n; i++) begin
      wd_q.push_back(32'hD000_0000 + 32'(exp_wseq));
      exp_wseq++;
    end
  endtask

  task automatic push_rdata(input logic [23:0] a, input int n);
    for (int i = 0; i < n; i++) rd_q.push_back({8'hA5, a + 24'(i)});
  endtask

  task automatic pop_cmd(input logic rd);
    logic [31:0] got;
    got = cmd(rd, l_if.local_address, l_if.local_size);
    chk("cmd_expected", 64'(cmd_q.size() != 0), 1);
    if (cmd_q.size() != 0) chk("cmd", got, cmd_q.pop_front());
  endtask

  // Ready driver: level or 50% toggle.
  initial begin
    l_if.local_ready = 1'b0;
    forever begin
      @(posedge mem_clk);
      #1;
      if (tgl) l_if.local_ready = ~l_if.local_ready;
      else     l_if.local_ready = ready_lvl;
    end
  end

  // Read responder: one beat per cycle from accepted command addresses, plus injected stray beats.
  initial begin
    l_if.local_rdata_valid = 1'b0;
    l_if.local_rdata = '0;
    forever begin
      @(posedge mem_clk);
      #1;
      stray_now = 1'b0;
      if (stray_req != stray_done) begin
        stray_done++;
        stray_now = 1'b1;
        l_if.local_rdata_valid = 1'b1;
        l_if.local_rdata = 32'hDEAD_0000;
      end else if (pend_q.size() != 0) begin
        l_if.local_rdata_valid = 1'b1;
        l_if.local_rdata = {8'hA5, pend_q.pop_front()};
      end else begin
        l_if.local_rdata_valid = 1'b0;
      end
    end
  end

  // Monitor and show-ahead write FIFO model.
  initial begin
    u_if.wr_burst_data = 32'hD000_0000;
    forever begin
      @(negedge mem_clk);
      if (rst_n && !abort_mode) begin
        if (l_if.local_read_req && l_if.local_write_req) overlap++;
        if (!l_if.local_init_done && (l_if.local_read_req || l_if.local_write_req)) bad_init++;
        if (bb_wait) chk("burstbegin_held", l_if.local_burstbegin, 1);
        if (l_if.local_write_req) begin
          chk("wr_pop", u_if.wr_burst_data_req, l_if.local_ready);
          if (l_if.local_ready) begin
            if (l_if.local_burstbegin) pop_cmd(1'b0);
            chk("wr_data_expected", 64'(wd_q.size() != 0), 1);
            if (wd_q.size() != 0) chk("wr_data", l_if.local_wdata, wd_q.pop_front());
          end
        end
        if (l_if.local_read_req && l_if.local_ready) begin
          chk("rd_burstbegin", l_if.local_burstbegin, 1);
          pop_cmd(1'b1);
          for (int i = 0; i < int'(l_if.local_size); i++)
            pend_q.push_back(l_if.local_address + 24'(i));
        end
        bb_wait = l_if.local_write_req & l_if.local_burstbegin & ~l_if.local_ready;
        if (stray_now && l_if.local_rdata_valid) begin
          chk("stray_valid", u_if.rd_burst_data_valid, 0);
        end else if (u_if.rd_burst_data_valid) begin
          chk("rd_data_expected", 64'(rd_q.size() != 0), 1);
          if (rd_q.size() != 0) chk("rd_data", u_if.rd_burst_data, rd_q.pop_front());
        end
        if (u_if.rd_burst_finish || u_if.wr_burst_finish) begin
          chk("burst_finish", u_if.burst_finish, 1);
          chk("fin_expected", 64'(fin_q.size() != 0), 1);
          if (fin_q.size() != 0)
            chk("fin_kind", {u_if.rd_burst_finish, u_if.wr_burst_finish}, fin_q.pop_front());
        end
      end else if (abort_mode && (u_if.rd_burst_finish || u_if.wr_burst_finish)) begin
        chk("abort_no_finish", 1, 0);
      end
      if (u_if.wr_burst_data_req) wr_idx++;
      u_if.wr_burst_data = 32'hD000_0000 + 32'(wr_idx);
    end
  end

  task automatic wait_fin(input bit rd, input string nm);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge mem_clk);
      seen = rd ? u_if.rd_burst_finish : u_if.wr_burst_finish;
    end
    if (!seen) chk(nm, 0, 1);
    if (rd) u_if.rd_burst_req = 1'b0;
    else    u_if.wr_burst_req = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_wreq"}, l_if.local_write_req, 0);
    chk({nm, "_rreq"}, l_if.local_read_req, 0);
    chk({nm, "_bb"}, l_if.local_burstbegin, 0);
    chk({nm, "_addr"}, l_if.local_address, 0);
    chk({nm, "_size"}, l_if.local_size, 0);
    chk({nm, "_pop"}, u_if.wr_burst_data_req, 0);
    chk({nm, "_fin"}, {u_if.rd_burst_finish, u_if.wr_burst_finish, u_if.burst_finish}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    u_if.rd_burst_req = 1'b0;
    u_if.wr_burst_req = 1'b0;
    u_if.rd_burst_len = '0;
    u_if.wr_burst_len = '0;
    u_if.rd_burst_addr = '0;
    u_if.wr_burst_addr = '0;
    l_if.local_init_done = 1'b0;
    repeat (3) @(negedge mem_clk);
    chk_idle_outputs("reset");
    chk("reset_be", l_if.local_be, 4'hF);
    rst_n = 1'b1;

    // Calibration not done: request must be ignored.
    @(negedge mem_clk);
    u_if.wr_burst_req = 1'b1; u_if.wr_burst_len = 10'd4; u_if.wr_burst_addr = 24'h50;
    repeat (20) @(negedge mem_clk);
    chk("init_hold_wreq", l_if.local_write_req, 0);
    chk("init_hold_fin", u_if.wr_burst_finish, 0);
    u_if.wr_burst_req = 1'b0;
    @(negedge mem_clk);
    l_if.local_init_done = 1'b1;
    repeat (2) @(negedge mem_clk);

    // Write len 10 at 0x100.
    cmd_q.push_back(cmd(0, 24'h100, 3'd4));
    cmd_q.push_back(cmd(0, 24'h104, 3'd4));
    cmd_q.push_back(cmd(0, 24'h108, 3'd2));
    push_wdata(10);
    fin_q.push_back(2'b01);
    u_if.wr_burst_req = 1'b1; u_if.wr_burst_len = 10'd10; u_if.wr_burst_addr = 24'h100;
    wait_fin(0, "timeout_wr10");

    // Read len 6 wrapping the address space.
    @(negedge mem_clk);
    cmd_q.push_back(cmd(1, 24'hFFFFFE, 3'd4));
    cmd_q.push_back(cmd(1, 24'h000002, 3'd2));
    push_rdata(24'hFFFFFE, 6);
    fin_q.push_back(2'b10);
    u_if.rd_burst_req = 1'b1; u_if.rd_burst_len = 10'd6; u_if.rd_burst_addr = 24'hFFFFFE;
    wait_fin(1, "timeout_rd6");

    // Stray read data while idle.
    repeat (2) @(negedge mem_clk);
    stray_req++;
    repeat (3) @(negedge mem_clk);

    // Contention twice: write, read, write.
    cmd_q.push_back(cmd(0, 24'h300, 3'd2));
    cmd_q.push_back(cmd(1, 24'h400, 3'd3));
    cmd_q.push_back(cmd(0, 24'h500, 3'd1));
    push_wdata(2);
    push_rdata(24'h400, 3);
    push_wdata(1);
    fin_q.push_back(2'b01); fin_q.push_back(2'b10); fin_q.push_back(2'b01);
    u_if.wr_burst_req = 1'b1; u_if.wr_burst_len = 10'd2; u_if.wr_burst_addr = 24'h300;
    u_if.rd_burst_req = 1'b1; u_if.rd_burst_len = 10'd3; u_if.rd_burst_addr = 24'h400;
    wait_fin(0, "timeout_arb_wr1");
    u_if.wr_burst_req = 1'b1; u_if.wr_burst_len = 10'd1; u_if.wr_burst_addr = 24'h500;
    wait_fin(1, "timeout_arb_rd");
    wait_fin(0, "timeout_arb_wr2");

    // Write len 7 with local_ready toggling.
    @(negedge mem_clk);
    tgl = 1'b1;
    cmd_q.push_back(cmd(0, 24'h200, 3'd4));
    cmd_q.push_back(cmd(0, 24'h204, 3'd3));
    push_wdata(7);
    fin_q.push_back(2'b01);
    u_if.wr_burst_req = 1'b1; u_if.wr_burst_len = 10'd7; u_if.wr_burst_addr = 24'h200;
    wait_fin(0, "timeout_wr7");
    tgl = 1'b0;
    ready_lvl = 1'b1;

    // Zero-length write.
    repeat (2) @(negedge mem_clk);
    fin_q.push_back(2'b01);
    u_if.wr_burst_req = 1'b1; u_if.wr_burst_len = 10'd0; u_if.wr_burst_addr = 24'h800;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge mem_clk);
      n++;
      if (u_if.wr_burst_finish) break;
    end
    chk("len0_finish_latency", 64'(n), 2);
    u_if.wr_burst_req = 1'b0;

    // Reset in the middle of a 20-beat write.
    repeat (2) @(negedge mem_clk);
    abort_mode = 1'b1;
    u_if.wr_burst_req = 1'b1; u_if.wr_burst_len = 10'd20; u_if.wr_burst_addr = 24'h600;
    repeat (6) @(negedge mem_clk);
    chk("abort_active", l_if.local_write_req, 1);
    rst_n = 1'b0;
    u_if.wr_burst_req = 1'b0;
    #1;
    chk_idle_outputs("abort");
    repeat (2) @(negedge mem_clk);
    rst_n = 1'b1;
    repeat (4) @(negedge mem_clk);
    exp_wseq = wr_idx;
    abort_mode = 1'b0;

    // Normal write after reset.
    cmd_q.push_back(cmd(0, 24'h700, 3'd3));
    push_wdata(3);
    fin_q.push_back(2'b01);
    u_if.wr_burst_req = 1'b1; u_if.wr_burst_len = 10'd3; u_if.wr_burst_addr = 24'h700;
    wait_fin(0, "timeout_post_reset");

    repeat (5) @(negedge mem_clk);
    chk("left_cmds", 64'(cmd_q.size()), 0);
    chk("left_wdata", 64'(wd_q.size()), 0);
    chk("left_rdata", 64'(rd_q.size()), 0);
    chk("left_fin", 64'(fin_q.size()), 0);
    chk("left_pending_beats", 64'(pend_q.size()), 0);
    chk("rd_wr_overlap", 64'(overlap), 0);
    chk("req_before_init", 64'(bad_init), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
